fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined RV32I core. It owns the PC register, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small queue. It presents them to the decode stage, which routes `instr[31:7]` to the immediate extend unit and the remaining fields to the control decoder. Branch and jump redirects from execute flush the queue and discard responses still in flight.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; PC, credit-limited imem requests, instr queue.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect faults and halts.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        id_ready,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
    localparam ptr_t        LAST  = AW'(DEPTH - 1);

    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    cnt_t        outstanding;
    cnt_t        drop_cnt;
    cnt_t        count;
    ptr_t        head;
    ptr_t        tail;
    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];

    logic        halted;
    logic        pop;
    logic        req_fire;
    logic        drop;
    logic        push;
    logic [CW:0] credit;
    logic [31:0] target;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic bad_target;
    assign bad_target = (redirect_pc[1:0] != 2'b00);

    // Sticky misalignment fault; only a redirect or reset can change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (redirect) begin
            halted <= bad_target;
        end
    end

    assign fetch_misaligned = halted;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb    = ^redirect_pc[1:0];
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign instr_valid    = (count != '0);
    assign instr          = q_instr[head];
    assign instr_pc       = q_pc[head];
    assign instr_pc_plus4 = q_pc[head] + 32'd4;

    assign pop = instr_valid && id_ready;

    // In-flight plus buffered words, counting this cycle's pop as freed.
    assign credit = {1'b0, outstanding} + {1'b0, count}
                  - {{CW{1'b0}}, pop};

    assign imem_req_valid = rst_n && !redirect && !halted
                          && (credit < LIMIT);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign drop = imem_rsp_valid && (drop_cnt != '0);
    assign push = imem_rsp_valid && !drop && !redirect;

    // PC tracking, in-flight count and stale-response drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(req_fire)
                         - cnt_t'(imem_rsp_valid);
            if (redirect) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= outstanding - cnt_t'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // Circular instruction queue; a redirect flushes it, same-cycle push too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_instr[tail] <= imem_rsp_data;
                q_pc[tail]    <= rsp_pc;
                tail          <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit against a queue-level memory and stream model.
// Directed startup/stall/redirect/wrap tables plus randomized traffic.
module tb_fetch_unit;

    localparam int DEPTH = 2;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit HALT_EXP = 1'b1;
`else
    localparam bit HALT_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        id_ready;
    logic        fetch_misaligned;

    logic        b_req_valid;
    logic [31:0] b_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_instr_valid;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;
    logic [31:0] b_instr_pc_plus4;
    logic        b_misaligned;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .id_ready(id_ready),
        .fetch_misaligned(fetch_misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(b_req_valid), .imem_req_ready(1'b1),
        .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc),
        .instr_pc_plus4(b_instr_pc_plus4), .id_ready(1'b1),
        .fetch_misaligned(b_misaligned)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] first;
        bit          halt;
    } rvec_t;

    mreq_t       memq[$];
    ent_t        mq[$];
    logic [31:0] b_addrs[$];

    int          cyc;
    int          lat;
    int          rmode;
    int          imode;
    int          ep;
    logic        idr_hold;
    logic [3:0]  pat;
    logic [31:0] exp_addr;
    bit          m_halt;
    bit          redir_req;
    logic [31:0] redir_tgt;
    logic        b_acc;

    logic        s_valid;
    logic [31:0] s_pc;

    int          checks;
    int          failures;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     nm, cyc, act, want);
        end
    endtask

    // One clock: drive at negedge, sample/check at +1, then advance model.
    task automatic step();
        bit    pop;
        bit    rsp;
        bit    exp_rv;
        mreq_t r;
        ent_t  e;
        mreq_t n;
        cyc++;
        @(negedge clk);
        if (rmode == 0)
            imem_req_ready = 1'b1;
        else if (rmode == 1)
            imem_req_ready = pat[cyc % 4];
        else
            imem_req_ready = 1'($urandom_range(0, 1));
        id_ready = (imode == 0) ? idr_hold : 1'($urandom_range(0, 1));
        rsp = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(memq[0].addr) : $urandom;
        redirect       = redir_req;
        redirect_pc    = redir_tgt;
        b_rsp_valid    = b_acc;
        b_rsp_data     = 32'h0000_0013;
        #1;
        chk("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].data);
            chk("instr_pc_plus4", instr_pc_plus4, mq[0].pc + 32'd4);
        end
        pop    = (mq.size() != 0) && id_ready;
        exp_rv = !redir_req && !m_halt
               && (memq.size() + mq.size() - int'(pop)) < DEPTH;
        chk("req_valid", imem_req_valid, exp_rv);
        if (imem_req_valid)
            chk("imem_addr", imem_addr, exp_addr);
        chk("credit", memq.size() + mq.size() <= DEPTH, 1);
        chk("misaligned", fetch_misaligned, m_halt);
        s_valid = instr_valid;
        s_pc    = instr_pc;
        if (b_req_valid)
            b_addrs.push_back(b_addr);
        b_acc = b_req_valid;

        if (pop)
            void'(mq.pop_front());
        if (rsp) begin
            r = memq.pop_front();
            if (r.ep == ep && !redir_req) begin
                e.pc   = r.addr;
                e.data = memword(r.addr);
                mq.push_back(e);
            end
        end
        if (redir_req) begin
            mq.delete();
            ep++;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_halt = (redir_tgt[1:0] != 2'b00);
`endif
            exp_addr  = {redir_tgt[31:2], 2'b00};
            redir_req = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
            n.addr = imem_addr;
            n.due  = cyc + lat;
            n.ep   = ep;
            memq.push_back(n);
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_misaligned", fetch_misaligned, 0);
        memq.delete();
        mq.delete();
        b_addrs.delete();
        exp_addr       = 32'h0;
        m_halt         = 1'b0;
        b_acc          = 1'b0;
        redir_req      = 1'b0;
        imem_rsp_valid = 1'b0;
        b_rsp_valid    = 1'b0;
        redirect       = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic startup_seq(input string tag);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 3) begin
                chk({tag, "_empty"}, s_valid, 0);
            end else begin
                chk({tag, "_valid"}, s_valid, 1);
                chk({tag, "_pc"}, s_pc, 32'(4 * (i - 3)));
            end
        end
    endtask

    rvec_t tv[6];

    initial begin
        logic [31:0] held;
        bit          found;
        checks = 0; failures = 0; cyc = 0; ep = 0;
        lat = 1; rmode = 0; imode = 0; idr_hold = 1'b1;
        pat = 4'b1001;
        redir_req = 1'b0; redir_tgt = 32'h0;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
        id_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;

        tv[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0};
        tv[1] = '{32'h0000_0102, 32'h0000_0100, HALT_EXP};
        tv[2] = '{32'h0000_0200, 32'h0000_0200, 1'b0};
        tv[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tv[4] = '{32'h0000_1003, 32'h0000_1000, HALT_EXP};
        tv[5] = '{32'h0000_0040, 32'h0000_0040, 1'b0};

        do_reset();
        startup_seq("startup");

        chk("wrap_count", b_addrs.size() >= 3, 1);
        while (b_addrs.size() < 3)
            b_addrs.push_back(32'hDEAD_BEEF);
        chk("wrap_addr0", b_addrs[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", b_addrs[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", b_addrs[2], 32'h0000_0000);

        idr_hold = 1'b0;
        held = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", s_valid, 1);
            if (i == 0)
                held = s_pc;
            else
                chk("stall_hold", s_pc, held);
        end
        idr_hold = 1'b1;
        for (int i = 0; i < 6; i++)
            step();

        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (memq.size() == 2);
        end
        chk("two_outstanding", found, 1);
        redir_req = 1'b1;
        redir_tgt = 32'h0000_0100;
        step();
        step();
        chk("flush_empty", s_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_valid;
        end
        chk("redir_seen", found, 1);
        chk("redir_pc0", s_pc, 32'h0000_0100);
        step();
        chk("redir_pc1", s_pc, 32'h0000_0104);

        rmode = 1;
        for (int i = 0; i < 24; i++)
            step();
        rmode = 0;

        lat = 1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++)
                step();
            redir_req = 1'b1;
            redir_tgt = tv[k].tgt;
            step();
            step();
            chk("tbl_r1_empty", s_valid, 0);
            step();
            chk("tbl_r2_empty", s_valid, 0);
            step();
            chk("tbl_r3_valid", s_valid, !tv[k].halt);
            if (!tv[k].halt)
                chk("tbl_r3_pc", s_pc, tv[k].first);
            step();
            chk("tbl_r4_valid", s_valid, !tv[k].halt);
            if (!tv[k].halt)
                chk("tbl_r4_pc", s_pc, tv[k].first + 32'd4);
        end

        rmode = 2;
        imode = 1;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0)
                lat = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0) begin
                redir_req = 1'b1;
                redir_tgt = $urandom;
            end
            step();
        end

        rmode = 0;
        imode = 0;
        idr_hold = 1'b1;
        lat = 1;
        for (int i = 0; i < 3; i++)
            step();
        do_reset();
        startup_seq("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
